// File: rtl/spart.sv
// SPART: processor-bus UART with a programmable 16-bit baud divisor, a 16x baud tick,
// an 8N1 transmitter and an 8N1 receiver.
module spart #(
    parameter logic [15:0] DB_RESET = 16'h028A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    localparam int unsigned DW = 8;
    localparam int unsigned BW = 16;
    localparam int unsigned TW = 4;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

    tx_state_e       tx_state_q, tx_state_d;
    rx_state_e       rx_state_q, rx_state_d;
    logic [BW-1:0]   db_q, db_d, cnt_q, cnt_d;
    logic [DW-1:0]   tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, rx_buf_q, rx_buf_d;
    logic [TW-1:0]   tx_tick_q, tx_tick_d, rx_tick_q, rx_tick_d;
    logic [CW-1:0]   tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic            txd_q, txd_d, tbr_q, tbr_d, rda_q, rda_d;
    logic            rx_s1_q, rx_s2_q, rx_prev_q;

    logic            wr_c, wr_tx_c, wr_lo_c, wr_hi_c, rd_rx_c, drive_c, tick_c;
    logic [DW-1:0]   rd_data_c;

    // Bus decode; the read path is combinational and released while in reset
    assign wr_c      = iocs & ~iorw;
    assign wr_tx_c   = wr_c & (ioaddr == 2'b01);
    assign wr_lo_c   = wr_c & (ioaddr == 2'b10);
    assign wr_hi_c   = wr_c & (ioaddr == 2'b11);
    assign rd_rx_c   = iocs & iorw & (ioaddr == 2'b00);
    assign drive_c   = rst & iocs & iorw & ~ioaddr[1];
    assign rd_data_c = ioaddr[0] ? {6'b0, tbr_q, rda_q} : rx_buf_q;
    assign databus   = drive_c ? rd_data_c : {DW{1'bz}};

    assign txd = txd_q;
    assign tbr = tbr_q;
    assign rda = rda_q;

    // Baud generator: counts down from DB, tick at zero; DB writes restart it
    assign tick_c = (cnt_q == '0);

    always_comb begin
        db_d = db_q;
        if (wr_lo_c) db_d[7:0]  = databus;
        if (wr_hi_c) db_d[15:8] = databus;
        if (wr_lo_c | wr_hi_c) cnt_d = db_d;
        else if (tick_c)       cnt_d = db_q;
        else                   cnt_d = cnt_q - 16'd1;
    end

    // Transmitter: each bit held for 16 ticks
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        txd_d      = txd_q;
        tbr_d      = tbr_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tbr_q) begin
                    if (wr_tx_c) begin
                        tx_shift_d = databus;
                        tbr_d      = 1'b0;
                    end
                end else if (tick_c) begin
                    tx_state_d = TX_START;
                    txd_d      = 1'b0;
                    tx_tick_d  = '0;
                end
            end
            TX_START: if (tick_c) begin
                tx_tick_d = tx_tick_q + 4'd1;
                if (tx_tick_q == 4'd15) begin
                    tx_state_d = TX_DATA;
                    txd_d      = tx_shift_q[0];
                    tx_bit_d   = '0;
                end
            end
            TX_DATA: if (tick_c) begin
                tx_tick_d = tx_tick_q + 4'd1;
                if (tx_tick_q == 4'd15) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end
            end
            TX_STOP: if (tick_c) begin
                tx_tick_d = tx_tick_q + 4'd1;
                if (tx_tick_q == 4'd15) begin
                    tx_state_d = TX_IDLE;
                    tbr_d      = 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Receiver: start verified at tick 8, then samples mid-bit every 16 ticks
    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_buf_d   = rx_buf_q;
        rda_d      = rda_q;
        if (rd_rx_c) rda_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_state_d = RX_START;
                rx_tick_d  = '0;
            end
            RX_START: if (tick_c) begin
                rx_tick_d = rx_tick_q + 4'd1;
                if (rx_tick_q == 4'd7) begin
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_tick_d  = '0;
                        rx_bit_d   = '0;
                    end
                end
            end
            RX_DATA: if (tick_c) begin
                rx_tick_d = rx_tick_q + 4'd1;
                if (rx_tick_q == 4'd15) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: if (tick_c) begin
                rx_tick_d = rx_tick_q + 4'd1;
                if (rx_tick_q == 4'd15) begin
                    if (rx_s2_q) begin
                        rx_buf_d   = rx_shift_q;
                        rda_d      = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_WAIT;
                    end
                end
            end
            RX_WAIT: if (rx_s2_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_q       <= DB_RESET;
            cnt_q      <= DB_RESET;
            tx_state_q <= TX_IDLE;
            rx_state_q <= RX_IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_buf_q   <= '0;
            tx_tick_q  <= '0;
            rx_tick_q  <= '0;
            tx_bit_q   <= '0;
            rx_bit_q   <= '0;
            txd_q      <= 1'b1;
            tbr_q      <= 1'b1;
            rda_q      <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            db_q       <= db_d;
            cnt_q      <= cnt_d;
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_buf_q   <= rx_buf_d;
            tx_tick_q  <= tx_tick_d;
            rx_tick_q  <= rx_tick_d;
            tx_bit_q   <= tx_bit_d;
            rx_bit_q   <= rx_bit_d;
            txd_q      <= txd_d;
            tbr_q      <= tbr_d;
            rda_q      <= rda_d;
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
        end
    end

endmodule

// File: tb/tb_spart.sv
// Directed bench for spart: reset/abort, divisor programming, TX framing, RX framing and errors,
// bus release. The data bus is pulled high so an undriven bus reads 8'hFF.
module tb_spart;

    logic       clk, rst, iocs, iorw, rxd, tb_en;
    logic [1:0] ioaddr;
    logic [7:0] tb_drv;
    tri1  [7:0] databus;
    logic       rda, tbr, txd;

    int         checks, errors;
    logic [7:0] d;
    int         n, gap;
    logic [9:0] exp_bits;
    logic       saw_low;

    assign databus = tb_en ? tb_drv : 8'bz;

    spart dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling clock edge
    task automatic bus_wr(input logic [1:0] a, input logic [7:0] v);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_drv = v; tb_en = 1'b1;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b1; tb_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] v);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1 v = databus;
        @(negedge clk);
        iocs = 1'b0;
    endtask

    task automatic wait_txd(input logic v, input int limit, output int cnt);
        cnt = 0;
        while (txd !== v && cnt < limit) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (64) @(negedge clk);
        end
        rxd = stop;
        repeat (64) @(negedge clk);
        rxd = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0;
        clk = 1'b0; rst = 1'b1; iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00;
        tb_drv = 8'h00; tb_en = 1'b0; rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b01;
        #1;
        chk("rst_bus_z", databus, 8'hFF);
        chk("rst_txd", txd, 1);
        chk("rst_tbr", tbr, 1);
        chk("rst_rda", rda, 0);
        @(negedge clk);
        iocs = 1'b0; rst = 1'b1;
        @(negedge clk);
        bus_rd(2'b01, d);
        chk("status_after_rst", d, 8'h02);

        // DB = 0x0145 -> 326-clock tick, 5216-clock bit
        bus_wr(2'b10, 8'h45);
        bus_wr(2'b11, 8'h01);
        bus_wr(2'b01, 8'h01);
        wait_txd(1'b0, 1000, n);
        chk("tx326_start_seen", txd, 0);
        wait_txd(1'b1, 20000, n);
        chk("tx326_bit_len", n, 5216);
        repeat (5216 + 2608) @(negedge clk);
        chk("tx326_bit1", txd, 0);
        // Abort mid-frame with a status read on the bus
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
        rst = 1'b0;
        #1;
        chk("abort_txd", txd, 1);
        chk("abort_tbr", tbr, 1);
        chk("abort_rda", rda, 0);
        chk("abort_bus_z", databus, 8'hFF);
        @(negedge clk);
        iocs = 1'b0; rst = 1'b1;
        @(negedge clk);

        // Reset divisor 0x028A -> 651-clock tick, 10416-clock bit
        bus_wr(2'b01, 8'h01);
        wait_txd(1'b0, 1000, n);
        chk("txdef_start_seen", txd, 0);
        wait_txd(1'b1, 20000, n);
        chk("txdef_bit_len", n, 10416);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // DB = 3 -> 4-clock tick, 64-clock bit
        bus_wr(2'b10, 8'h03);
        bus_wr(2'b11, 8'h00);
        bus_wr(2'b01, 8'hA5);
        chk("tbr_fall", tbr, 0);
        wait_txd(1'b0, 100, n);
        chk("tx_start_seen", txd, 0);
        wait_txd(1'b1, 200, n);
        chk("tx_start_len", n, 64);
        exp_bits = {1'b1, 8'hA5, 1'b0};
        gap = 32;
        for (int k = 1; k < 10; k++) begin
            repeat (gap) @(negedge clk);
            chk($sformatf("tx_bit%0d", k), txd, exp_bits[k]);
            gap = 64;
            if (k == 2) begin
                bus_wr(2'b01, 8'hFF);
                gap = 63;
            end
        end
        chk("tbr_mid_stop", tbr, 0);
        n = 0;
        while (!tbr && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tbr_rise", tbr, 1);
        chk("tbr_rise_time", n, 32);
        saw_low = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (!txd) saw_low = 1'b1;
        end
        chk("no_second_frame", saw_low, 0);

        // Receive 8'h3C
        send_rx(8'h3C, 1'b1);
        chk("rx_rda_set", rda, 1);
        bus_rd(2'b01, d);
        chk("rx_status", d, 8'h03);
        chk("rda_after_status", rda, 1);
        bus_rd(2'b00, d);
        chk("rx_data_3c", d, 8'h3C);
        chk("rda_clear", rda, 0);

        // 16-clock glitch is a false start
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        chk("false_start_rda", rda, 0);

        // Framing error keeps the old byte
        send_rx(8'h5A, 1'b0);
        repeat (64) @(negedge clk);
        chk("frame_err_rda", rda, 0);
        bus_rd(2'b00, d);
        chk("frame_err_buf", d, 8'h3C);

        // Overrun: second byte wins
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        chk("overrun_rda", rda, 1);
        bus_rd(2'b00, d);
        chk("overrun_data", d, 8'h22);

        // Bus release
        for (int a = 2; a < 4; a++) begin
            iocs = 1'b1; iorw = 1'b1; ioaddr = 2'(a);
            #1 chk($sformatf("bus_z_rd%0d", a), databus, 8'hFF);
            @(negedge clk);
        end
        for (int a = 0; a < 4; a++) begin
            iocs = 1'b0; iorw = 1'b1; ioaddr = 2'(a);
            #1 chk($sformatf("bus_z_nocs%0d", a), databus, 8'hFF);
            @(negedge clk);
        end
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00;
        #1 chk("bus_z_write", databus, 8'hFF);
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
